player_motion: RTL
==================

# player_motion

Per-frame player physics stage that sits directly upstream of the frame datapath and drives its `player_x`/`player_y` inputs. It synchronizes the jump and left/right buttons, advances a small vertical-velocity state machine once per `sig_next_frame` pulse, and clamps the result to the 160x80 playfield. While the core is not in PLAY it holds the player at the spawn point.

## Interface
- `START_X`, 20: spawn column; also the reset value of `player_x`.
- `GROUND_Y`, 72: resting row (sprite top-left); the lowest legal `player_y`.
- `X_MIN`, 0 / `X_MAX`, 152: inclusive horizontal clamp bounds.
- `JUMP_VEL`, 6: upward speed loaded on a jump, in px/frame.
- `MAX_FALL`, 4: terminal downward speed, in px/frame.

- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `frame_tick`  in  1  one-cycle pulse; connects to the datapath `sig_next_frame`.
- `core_state`  in  2  WAIT=0, PLAY=1, END=2.
- `btn_jump`, `btn_left`, `btn_right`  in  1 each  raw, asynchronous, active-high.
- `player_x`  out  8  sprite column.
- `player_y`  out  7  sprite row.
- `airborne`  out  1  high in RISING or FALLING.
- `jump_count`  out  8  jumps taken since leaving WAIT; saturates at 255.

## Operation
- Each button passes through a 2-flop synchronizer. A rising edge of synced `btn_jump` sets `jump_req`. `jump_req` clears on the next `frame_tick`, or when `core_state` is not PLAY.
- States:
  - HOLD: entered whenever `core_state` is not PLAY. Forces `player_x=START_X`, `player_y=GROUND_Y`, `vy=0`. Clears `jump_count` only in WAIT; END freezes the count.
  - HOLD → GROUNDED on the first cycle with `core_state==PLAY`.
- On `frame_tick` in PLAY, the transitions are:
  - GROUNDED + `jump_req`: `vy=JUMP_VEL`, go to RISING, `jump_count++`.
  - RISING: `y_next = y - vy`, then `vy--`. When `vy` reaches 0, go to FALLING.
  - FALLING: `y_next = y + vy`, then `vy = min(vy+1, MAX_FALL)`.
- Vertical arithmetic:
  - `vy` is 4-bit unsigned speed; direction is implied by the state.
  - Intermediate y is 8-bit signed.
  - If `y_next <= 0`: set y=0, vy=0, go to FALLING (ceiling hit).
  - If `y_next >= GROUND_Y`: set y=GROUND_Y, vy=0, go to GROUNDED (landing).
- Horizontal, applied on the same tick:
  - left only: x-1; right only: x+1; both or neither: no move.
  - Clamp to `X_MIN..X_MAX`. No wrap-around.
- Mid-air `jump_req` is discarded at the tick, unless `PLAYER_DOUBLE_JUMP_EN` is defined (see Configuration).

## Timing
- Reset values: `player_x=START_X`, `player_y=GROUND_Y`, `airborne=0`, `jump_count=0`, `vy=0`, state HOLD, `jump_req=0`.
- All outputs are registered. New position is visible the cycle after `frame_tick`, so it is stable for the entire next frame scan.
- Button-to-request latency: 3 cycles (2 sync + edge).
- A jump edge detected in the same cycle as `frame_tick` is honoured at that tick.
- `frame_tick` outside PLAY is ignored.
- `core_state` leaving PLAY mid-jump: next cycle goes to HOLD with spawn position; no partial update is applied.
- Landing and a pending jump on the same tick: land only. The request is consumed and a new press is required.
- `reset` asserted mid-operation: all registers take reset values immediately (asynchronous). Release is synchronized to `clock`.

## Configuration
- `PLAYER_DOUBLE_JUMP_EN`:
  - Defined: one extra jump is allowed per airborne period. `jump_req` in RISING or FALLING reloads `vy=JUMP_VEL`, enters RISING, increments `jump_count`, and sets `dj_used`. `dj_used` clears on landing or HOLD.
  - Undefined: `dj_used` logic is absent, and mid-air requests are dropped.

## Structure
- Shared package `game_pkg`:
  - `core_state` encodings (O_S_WAIT/PLAY/END).
  - Playfield constants (160x80 visible, 160x120 screen).
  - The motion-state enum (HOLD, GROUNDED, RISING, FALLING).
- One sub-module: `button_sync`, a 2-flop synchronizer plus rising-edge detector. It is instantiated three times; only the jump instance uses the edge output.

## Test plan
- Reset, then PLAY, no buttons, 10 ticks → `player_x`=20, `player_y`=72, `airborne`=0 throughout.
- Jump press, then ticks → y sequence 66, 61, 57, 54, 52, 51, 51, 52, 54, 57, 61, 65, 69, 72; `airborne` drops on the 72 tick; `jump_count`=1.
- `btn_right` held 200 ticks from x=20 → x reaches 152 and stays. Both buttons held → x unchanged.
- `core_state` to END while y=54 → next cycle position (20,72), `jump_count` held. WAIT → count cleared.
- Jump edge coincident with `frame_tick` → y=66 on that tick. Second press mid-air → ignored, or re-launch with count=2 when `PLAYER_DOUBLE_JUMP_EN` is defined.
- Assert `reset` asynchronously mid-RISING → outputs at reset values before the next clock edge.

Source files
------------

// File: rtl/game_pkg.sv
// Shared encodings and playfield constants for the game core and its
// per-frame stages (core state, playfield geometry, player motion states).
package game_pkg;

  localparam logic [1:0] O_S_WAIT = 2'd0;
  localparam logic [1:0] O_S_PLAY = 2'd1;
  localparam logic [1:0] O_S_END  = 2'd2;

  localparam int unsigned PLAYFIELD_W = 160;
  localparam int unsigned PLAYFIELD_H = 80;
  localparam int unsigned SCREEN_W    = 160;
  localparam int unsigned SCREEN_H    = 120;
  localparam int unsigned SPRITE_SIZE = 8;

  typedef enum logic [1:0] {
    M_HOLD     = 2'd0,
    M_GROUNDED = 2'd1,
    M_RISING   = 2'd2,
    M_FALLING  = 2'd3
  } motion_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/button_sync.sv
// Two-flop synchronizer for a raw push button, plus a rising-edge strobe
// taken one flop further down the chain.
module button_sync (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic rise
);

  // [0],[1] synchronize; [2] remembers the previous synced level
  logic [2:0] sync_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[1:0], btn};
    end
  end

  assign level = sync_reg[1];
  assign rise  = sync_reg[1] & ~sync_reg[2];

endmodule

// File: rtl/player_motion.sv
// Per-frame player physics: button sync, jump/fall state machine and playfield
// clamping. Define PLAYER_DOUBLE_JUMP_EN to allow one extra mid-air jump.
module player_motion
  import game_pkg::*;
#(
  parameter int unsigned START_X  = 20,
  parameter int unsigned GROUND_Y = PLAYFIELD_H - SPRITE_SIZE,
  parameter int unsigned X_MIN    = 0,
  parameter int unsigned X_MAX    = PLAYFIELD_W - SPRITE_SIZE,
  parameter int unsigned JUMP_VEL = 6,
  parameter int unsigned MAX_FALL = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [1:0] core_state,
  input  logic       btn_jump,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic [7:0] player_x,
  output logic [6:0] player_y,
  output logic       airborne,
  output logic [7:0] jump_count
);

  localparam logic [7:0]        START_X8  = 8'(START_X);
  localparam logic [7:0]        X_MIN8    = 8'(X_MIN);
  localparam logic [7:0]        X_MAX8    = 8'(X_MAX);
  localparam logic [6:0]        GROUND_Y7 = 7'(GROUND_Y);
  localparam logic signed [7:0] GROUND_YS = 8'(GROUND_Y);
  localparam logic [3:0]        JUMP_VEL4 = 4'(JUMP_VEL);
  localparam logic [3:0]        MAX_FALL4 = 4'(MAX_FALL);

  // Button synchronizers: index 0 jump, 1 left, 2 right
  logic [2:0] btn_raw;
  logic [2:0] btn_level;
  logic [2:0] btn_rise;
  logic [2:0] unused_sync;

  assign btn_raw = {btn_right, btn_left, btn_jump};

  for (genvar gi = 0; gi < 3; gi++) begin : g_sync
    button_sync u_sync (
      .clock (clock),
      .reset (reset),
      .btn   (btn_raw[gi]),
      .level (btn_level[gi]),
      .rise  (btn_rise[gi])
    );
  end

  assign unused_sync = {btn_rise[2:1], btn_level[0]};

  logic          jump_rise;
  logic          left_level;
  logic          right_level;

  assign jump_rise   = btn_rise[0];
  assign left_level  = btn_level[1];
  assign right_level = btn_level[2];

  motion_state_t state_reg;
  logic [3:0]    vy_reg;
  logic          jump_req_reg;
  logic [7:0]    x_reg;
  logic [6:0]    y_reg;
  logic          airborne_reg;
  logic [7:0]    jump_count_reg;
`ifdef PLAYER_DOUBLE_JUMP_EN
  logic          dj_used_reg;
  logic signed [7:0] fall_y;
`endif

  logic [7:0]        x_next;
  logic              jump_go;
  logic              launch;
  logic              going_up;
  logic [3:0]        vy_eff;
  logic [3:0]        vy_after;
  logic signed [7:0] y_ext;
  logic signed [7:0] vy_ext;
  logic signed [7:0] y_calc;

  // An edge arriving in the same cycle as the tick still counts for that tick
  assign jump_go = jump_req_reg | jump_rise;

  always_comb begin
    x_next = x_reg;
    if (left_level && !right_level && (x_reg > X_MIN8)) begin
      x_next = x_reg - 8'd1;
    end else if (right_level && !left_level && (x_reg < X_MAX8)) begin
      x_next = x_reg + 8'd1;
    end
  end

  always_comb begin
    y_ext  = signed'({1'b0, y_reg});
    launch = 1'b0;
`ifdef PLAYER_DOUBLE_JUMP_EN
    fall_y = y_ext + signed'({4'b0000, vy_reg});
`endif
    if (jump_go) begin
      if (state_reg == M_GROUNDED) begin
        launch = 1'b1;
`ifdef PLAYER_DOUBLE_JUMP_EN
      // A landing tick wins over a second jump
      end else if ((state_reg == M_RISING ||
                    (state_reg == M_FALLING && fall_y < GROUND_YS)) &&
                   !dj_used_reg) begin
        launch = 1'b1;
`endif
      end
    end

    vy_eff   = launch ? JUMP_VEL4 : vy_reg;
    going_up = launch || (state_reg == M_RISING);
    vy_ext   = signed'({4'b0000, vy_eff});
    y_calc   = going_up ? (y_ext - vy_ext) : (y_ext + vy_ext);

    if (going_up) begin
      vy_after = vy_eff - 4'd1;
    end else if (vy_eff >= MAX_FALL4) begin
      vy_after = MAX_FALL4;
    end else begin
      vy_after = vy_eff + 4'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= M_HOLD;
      vy_reg         <= '0;
      jump_req_reg   <= 1'b0;
      x_reg          <= START_X8;
      y_reg          <= GROUND_Y7;
      airborne_reg   <= 1'b0;
      jump_count_reg <= '0;
`ifdef PLAYER_DOUBLE_JUMP_EN
      dj_used_reg    <= 1'b0;
`endif
    end else if (core_state != O_S_PLAY) begin
      state_reg    <= M_HOLD;
      vy_reg       <= '0;
      jump_req_reg <= 1'b0;
      x_reg        <= START_X8;
      y_reg        <= GROUND_Y7;
      airborne_reg <= 1'b0;
`ifdef PLAYER_DOUBLE_JUMP_EN
      dj_used_reg  <= 1'b0;
`endif
      if (core_state == O_S_WAIT) begin
        jump_count_reg <= '0;
      end
    end else begin
      jump_req_reg <= frame_tick ? 1'b0 : (jump_req_reg | jump_rise);
      case (state_reg)
        M_HOLD: begin
          state_reg <= M_GROUNDED;
        end
        default: begin
          if (frame_tick) begin
            x_reg <= x_next;
            if (launch) begin
              jump_count_reg <= sat_inc8(jump_count_reg);
            end
`ifdef PLAYER_DOUBLE_JUMP_EN
            if (launch && state_reg != M_GROUNDED) begin
              dj_used_reg <= 1'b1;
            end
`endif
            if (state_reg == M_GROUNDED && !launch) begin
              y_reg <= y_reg;
            end else if (y_calc <= 8'sd0) begin
              y_reg        <= '0;
              vy_reg       <= '0;
              state_reg    <= M_FALLING;
              airborne_reg <= 1'b1;
            end else if (y_calc >= GROUND_YS) begin
              y_reg        <= GROUND_Y7;
              vy_reg       <= '0;
              state_reg    <= M_GROUNDED;
              airborne_reg <= 1'b0;
`ifdef PLAYER_DOUBLE_JUMP_EN
              dj_used_reg  <= 1'b0;
`endif
            end else begin
              y_reg        <= y_calc[6:0];
              vy_reg       <= vy_after;
              airborne_reg <= 1'b1;
              if (going_up && vy_after != 4'd0) begin
                state_reg <= M_RISING;
              end else begin
                state_reg <= M_FALLING;
              end
            end
          end
        end
      endcase
    end
  end

  assign player_x   = x_reg;
  assign player_y   = y_reg;
  assign airborne   = airborne_reg;
  assign jump_count = jump_count_reg;

endmodule
